// File: rtl/mux_3_1_axis_arbiter.sv
// Packet-level round-robin arbiter for a 3:1 AXI-Stream mux. The grant is held until the TLAST
// beat, and a stall watchdog raises block when the granted stream makes no progress.
module mux_3_1_axis_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [3*DATA_W-1:0] s_tdata,
  input  logic [2:0]          s_tvalid,
  input  logic [2:0]          s_tlast,
  output logic [2:0]          s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                block
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StXfer = 2'b01
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   stall_cnt;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               in_xfer;
  logic               beat;
  logic [1:0]         cand1, cand2, cand3, pick;

  function automatic logic [1:0] inc_mod3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Rotating priority: the stream after the last grant is searched first.
  always_comb begin
    cand1 = inc_mod3(grant_id);
    cand2 = inc_mod3(cand1);
    cand3 = inc_mod3(cand2);
    if (s_tvalid[cand1])      pick = cand1;
    else if (s_tvalid[cand2]) pick = cand2;
    else                      pick = cand3;
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    case (grant_id)
      2'd0: begin
        sel_data  = s_tdata[0 +: DATA_W];
        sel_valid = s_tvalid[0];
        sel_last  = s_tlast[0];
      end
      2'd1: begin
        sel_data  = s_tdata[DATA_W +: DATA_W];
        sel_valid = s_tvalid[1];
        sel_last  = s_tlast[1];
      end
      2'd2: begin
        sel_data  = s_tdata[2*DATA_W +: DATA_W];
        sel_valid = s_tvalid[2];
        sel_last  = s_tlast[2];
      end
      default: ;
    endcase
  end

  assign in_xfer = (state == StXfer);
  assign beat    = in_xfer && sel_valid && m_tready;

  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = 3'b000;
    if (in_xfer) begin
      m_tdata  = sel_data;
      m_tvalid = sel_valid;
      m_tlast  = sel_last;
      case (grant_id)
        2'd0:    s_tready = {2'b00, m_tready};
        2'd1:    s_tready = {1'b0, m_tready, 1'b0};
        2'd2:    s_tready = {m_tready, 2'b00};
        default: s_tready = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      grant_id  <= 2'd2;
      stall_cnt <= '0;
      block     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          stall_cnt <= '0;
          block     <= 1'b0;
          if (enable && |s_tvalid) begin
            grant_id <= pick;
            state    <= StXfer;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        StXfer: begin
          if (beat) begin
            stall_cnt <= '0;
          end else if (stall_cnt != CNT_W'(TIMEOUT)) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          block <= !beat && ((stall_cnt == CNT_W'(TIMEOUT - 1)) || block);
          if (beat && sel_last) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          stall_cnt <= '0;
          block     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
